video_fetch: RTL

VIDEO_FETCH -- requirements
Module: video_fetch

---
 rtl/video_fetch_if.sv | 11 +
 rtl/video_fetch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/video_fetch_if.sv
// Read-port bus between the line fetcher and the video dual-port RAM.
// The fetcher drives a registered word address; the RAM returns 16-bit data.
interface video_fetch_if #(
    parameter int ADDRWIDTH = 14
) ();
    logic [ADDRWIDTH-1:0] rdaddress;
    logic [15:0]          q;

    modport master (output rdaddress, input q);
    modport slave  (input rdaddress, output q);
endinterface

// File: rtl/video_fetch.sv
// Per-line pixel fetcher: streams 64 RAM words per line through a shift/holding
// register pair and serialises them into 4-colour or 8-colour+flash pixels.
module video_fetch #(
    parameter int ADDRWIDTH = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce_pix,
    input  logic         line_start,
    input  logic [7:0]   line_num,
    input  logic         active,
    input  logic         mode8,
    video_fetch_if.master ram,
    output logic [2:0]   pix_rgb,
    output logic         pix_flash,
    output logic         pix_valid,
    output logic         underrun
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [7:0]           line_reg;
    logic                 mode8_reg;
    logic [5:0]           word_idx_reg;
    logic [2:0]           slot_reg;
    logic [1:0]           prime_cnt_reg;
    logic [15:0]          shift_reg, hold_reg;
    logic [ADDRWIDTH-1:0] rdaddress_reg;
    // Two-stage tag pipeline tracking fetches in flight; dst: 0 = shift, 1 = hold
    logic                 issue1_reg, issue2_reg, dst1_reg, dst2_reg;
    logic                 slot_fire, underrun_fire, word_end;
    logic [2:0]           sh_amt;
    logic [15:0]          sh_word;

    assign ram.rdaddress = rdaddress_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        slot_fire     = 1'b0;
        underrun_fire = 1'b0;
        word_end      = 1'b0;
        if (line_start) begin
            state_next = PRIME;
        end else begin
            case (state_reg)
                PRIME: begin
                    underrun_fire = ce_pix & active;
                    if (prime_cnt_reg == 2'd2) state_next = RUN;
                end
                RUN: begin
                    slot_fire = ce_pix & active;
                    word_end  = slot_fire && (slot_reg == 3'd7);
                    if (word_end && (word_idx_reg == 6'd63)) state_next = DONE;
                end
                default: ;
            endcase
        end
    end

    // Shifting left by the pixel index puts G/flash at bits 15/14 and R/B at 7/6.
    always_comb begin
        sh_amt  = mode8_reg ? {slot_reg[2:1], 1'b0} : slot_reg;
        sh_word = shift_reg << sh_amt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_reg      <= '0;
            mode8_reg     <= 1'b0;
            word_idx_reg  <= '0;
            slot_reg      <= '0;
            prime_cnt_reg <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            rdaddress_reg <= '0;
            issue1_reg    <= 1'b0;
            issue2_reg    <= 1'b0;
            dst1_reg      <= 1'b0;
            dst2_reg      <= 1'b0;
            pix_rgb       <= '0;
            pix_flash     <= 1'b0;
            pix_valid     <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            underrun   <= 1'b0;
            issue1_reg <= 1'b0;
            issue2_reg <= issue1_reg;
            dst2_reg   <= dst1_reg;
            if (issue2_reg) begin
                if (dst2_reg) hold_reg  <= ram.q;
                else          shift_reg <= ram.q;
            end

            if (ce_pix) begin
                pix_valid <= 1'b0;
                pix_rgb   <= '0;
                pix_flash <= 1'b0;
                if (slot_fire) begin
                    pix_valid <= 1'b1;
                    pix_rgb   <= {sh_word[15], sh_word[7],
                                  mode8_reg ? sh_word[6] : (sh_word[15] & sh_word[7])};
                    pix_flash <= mode8_reg & sh_word[14];
                end else if (underrun_fire) begin
                    pix_valid <= 1'b1;
                    underrun  <= 1'b1;
                end
            end

            if (line_start) begin
                line_reg      <= line_num;
                mode8_reg     <= mode8;
                word_idx_reg  <= '0;
                slot_reg      <= '0;
                prime_cnt_reg <= '0;
                rdaddress_reg <= ADDRWIDTH'({line_num, 6'd0});
                issue1_reg    <= 1'b1;
                dst1_reg      <= 1'b0;
                issue2_reg    <= 1'b0;  // drop any fetch still in flight from the old line
            end else begin
                if (state_reg == PRIME) begin
                    prime_cnt_reg <= prime_cnt_reg + 2'd1;
                    if (prime_cnt_reg == 2'd0) begin
                        rdaddress_reg <= ADDRWIDTH'({line_reg, 6'd1});
                        issue1_reg    <= 1'b1;
                        dst1_reg      <= 1'b1;
                    end
                end
                if (slot_fire) begin
                    slot_reg <= slot_reg + 3'd1;
                    if (word_end) begin
                        shift_reg    <= hold_reg;
                        word_idx_reg <= word_idx_reg + 6'd1;
                        if (word_idx_reg <= 6'd61) begin
                            rdaddress_reg <= ADDRWIDTH'({line_reg, 6'(word_idx_reg + 6'd2)});
                            issue1_reg    <= 1'b1;
                            dst1_reg      <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
